// File: rtl/decode_event_fifo_pkg.sv
// Shared definitions for the decoder2 event path: code width, code constants, event packing.
// Events are packed as {code, stamp}; the stamp width is chosen per instance.
package decode_event_fifo_pkg;

  localparam int CODE_W = 2;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t CODE_00 = 2'b00;
  localparam code_t CODE_01 = 2'b01;
  localparam code_t CODE_10 = 2'b10;
  localparam code_t CODE_11 = 2'b11;

  function automatic int evt_w(input int ts_w);
    return CODE_W + ts_w;
  endfunction

endpackage

// File: rtl/decode_event_fifo_sync_fifo.sv
// Generic show-ahead synchronous FIFO: dout reflects the head whenever empty=0, one-cycle write-to-read.
// A push when full is accepted only if a pop happens in the same cycle; a pop when empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (level_q == DEPTH_C);
  assign empty = (level_q == '0);
  assign level = level_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop & ~empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    level_d = level_q;
    if (do_push & ~do_pop) begin
      level_d = level_q + (AW+1)'(1);
    end else if (~do_push & do_pop) begin
      level_d = level_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/decode_event_fifo.sv
// Glitch-filters the decoder2 code, timestamps each accepted change and queues it; push lands STABLE-1
// cycles after a change is first sampled, visible one cycle later. Full FIFO without a pop drops and sets overflow.
module decode_event_fifo
  import decode_event_fifo_pkg::*;
#(
  parameter int STABLE = 4,
  parameter int DEPTH  = 4,
  parameter int TS_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CODE_W-1:0]      code_in,
  output logic [CODE_W-1:0]      out_code,
  output logic [TS_W-1:0]        out_stamp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   clear_ovf
);

  localparam int EVT_W = evt_w(TS_W);
  localparam int CNT_W = $clog2(STABLE + 1);
  localparam logic [CNT_W:0] STB = (CNT_W+1)'(STABLE);

  logic [TS_W-1:0]   ts_q;
  code_t             cand_q;
  code_t             cand_d;
  code_t             acc_q;
  code_t             acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              ovf_q;
  logic              ovf_d;
  logic [CNT_W:0]    run;
  logic              evt;
  logic              pop;
  logic              full;
  logic              empty;
  logic [EVT_W-1:0]  dout;

  assign out_valid = ~empty;
  assign out_code  = dout[EVT_W-1:TS_W];
  assign out_stamp = dout[TS_W-1:0];
  assign overflow  = ovf_q;

  always_comb begin
    // run is the count of identical samples including this cycle's.
    run    = (code_in == cand_q) ? ({1'b0, cnt_q} + (CNT_W+1)'(1)) : (CNT_W+1)'(1);
    cand_d = code_in;
    cnt_d  = (run >= STB) ? STB[CNT_W-1:0] : run[CNT_W-1:0];
    evt    = (run >= STB) && (code_in != acc_q);
    acc_d  = evt ? code_in : acc_q;
    pop    = out_valid & out_ready;
    if (evt & full & ~pop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q   <= '0;
      cand_q <= CODE_00;
      acc_q  <= CODE_00;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_q + TS_W'(1);
      cand_q <= cand_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .din   ({code_in, ts_q}),
    .pop   (pop),
    .dout  (dout),
    .level (level),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_decode_event_fifo.sv
// Bench for decode_event_fifo: directed scenarios plus randomized codes against an event-queue model.
module tb_decode_event_fifo;
  import decode_event_fifo_pkg::*;

  localparam int STABLE = 4;
  localparam int DEPTH  = 4;
  localparam int TS_W   = 8;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      code_in = 2'b00;
  logic            out_ready = 1'b0;
  logic            clear_ovf = 1'b0;
  logic [1:0]      out_code;
  logic [TS_W-1:0] out_stamp;
  logic            out_valid;
  logic [LW-1:0]   level;
  logic            overflow;

  always #5 clk = ~clk;

  decode_event_fifo #(.STABLE(STABLE), .DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .out_code  (out_code),
    .out_stamp (out_stamp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf)
  );

  int checks = 0;
  int passed = 0;

  // Reference model: a run-length of identical samples, the last accepted code, and a queue of events.
  typedef struct {
    logic [1:0]      code;
    logic [TS_W-1:0] stamp;
  } evt_t;

  evt_t            mq[$];
  logic [TS_W-1:0] m_ts;
  logic [1:0]      m_prev;
  logic [1:0]      m_acc;
  int              m_run;
  bit              m_ovf;

  task automatic model_reset();
    mq.delete();
    m_ts   = '0;
    m_prev = 2'b00;
    m_acc  = 2'b00;
    m_run  = 0;
    m_ovf  = 1'b0;
  endtask

  task automatic model_step();
    bit   drop;
    evt_t e;
    drop = 1'b0;
    if (code_in == m_prev) m_run = (m_run < STABLE) ? m_run + 1 : STABLE;
    else m_run = 1;
    m_prev = code_in;
    if (mq.size() != 0 && out_ready) void'(mq.pop_front());
    if (m_run >= STABLE && code_in != m_acc) begin
      m_acc = code_in;
      if (mq.size() < DEPTH) begin
        e.code  = code_in;
        e.stamp = m_ts;
        mq.push_back(e);
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) m_ovf = 1'b1;
    else if (clear_ovf) m_ovf = 1'b0;
    m_ts = m_ts + 1'b1;
  endtask

  // Inputs change at negedge; the model advances at posedge from the same stable inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    code_in = 2'b00;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", out_valid); else passed++;
      checks++; if (level !== '0) $display("FAIL rst_level: got %0d want 0", level); else passed++;
      checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %0b want 0", overflow); else passed++;
    end
    checks++; if (out_code !== 2'b00) $display("FAIL rst_code: got %0b want 00", out_code); else passed++;
    checks++; if (out_stamp !== '0) $display("FAIL rst_stamp: got %0d want 0", out_stamp); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_first_event();
    repeat (10) tick();
    checks++; if (level !== '0) $display("FAIL no_evt_after_release: level got %0d want 0", level); else passed++;
    code_in = 2'b10;
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL early_valid: got %0b want 0", out_valid); else passed++;
    tick();
    checks++; if (out_valid !== 1'b1) $display("FAIL first_valid: got %0b want 1", out_valid); else passed++;
    checks++; if (out_code !== 2'b10) $display("FAIL first_code: got %0b want 10", out_code); else passed++;
    checks++; if (out_stamp !== 8'd13) $display("FAIL first_stamp: got %0d want 13", out_stamp); else passed++;
    checks++; if (level !== LW'(1)) $display("FAIL first_level: got %0d want 1", level); else passed++;
  endtask

  task automatic test_glitch();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    code_in = 2'b00; repeat (6) tick();
    checks++; if (level !== LW'(1) || out_code !== 2'b00)
      $display("FAIL back_to_00: level %0d code %0b want 1 / 00", level, out_code); else passed++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    code_in = 2'b01; repeat (3) tick();
    code_in = 2'b00; repeat (6) tick();
    checks++; if (level !== '0) $display("FAIL glitch3: level got %0d want 0", level); else passed++;
    code_in = 2'b10; repeat (6) tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    code_in = 2'b01; tick();
    code_in = 2'b10; repeat (6) tick();
    checks++; if (level !== '0) $display("FAIL glitch1: level got %0d want 0", level); else passed++;
    checks++; if (level !== LW'(mq.size())) $display("FAIL glitch_model: level %0d model %0d", level, mq.size()); else passed++;
  endtask

  task automatic test_overflow();
    logic [1:0] seq [5];
    seq = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      code_in = seq[i];
      repeat (6) tick();
    end
    checks++; if (level !== LW'(DEPTH)) $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); else passed++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %0b want 1", overflow); else passed++;
    checks++; if (out_code !== 2'b01) $display("FAIL ovf_head: got %0b want 01", out_code); else passed++;
    checks++; if (out_stamp !== mq[0].stamp) $display("FAIL ovf_head_stamp: got %0d want %0d", out_stamp, mq[0].stamp); else passed++;
    clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
    checks++; if (overflow !== 1'b0) $display("FAIL clear_ovf: got %0b want 0", overflow); else passed++;
  endtask

  task automatic test_full_pop();
    logic [1:0] exp [4];
    exp = '{2'b10, 2'b11, 2'b00, 2'b10};
    code_in = 2'b10;
    repeat (3) tick();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (level !== LW'(DEPTH)) $display("FAIL fullpop_level: got %0d want %0d", level, DEPTH); else passed++;
    checks++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %0b want 0", overflow); else passed++;
    checks++; if (out_code !== 2'b10) $display("FAIL fullpop_head: got %0b want 10", out_code); else passed++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_code !== exp[i])
        $display("FAIL drain_code%0d: valid %0b code %0b want 1 / %0b", i, out_valid, out_code, exp[i]); else passed++;
      checks++; if (out_stamp !== mq[0].stamp)
        $display("FAIL drain_stamp%0d: got %0d want %0d", i, out_stamp, mq[0].stamp); else passed++;
      tick();
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0 || level !== '0)
      $display("FAIL drain_empty: valid %0b level %0d want 0 / 0", out_valid, level); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [1:0] seq [3];
    seq = '{2'b01, 2'b11, 2'b00};
    for (int i = 0; i < 3; i++) begin
      code_in = seq[i];
      repeat (6) tick();
    end
    checks++; if (level !== LW'(3)) $display("FAIL mid_pre_level: got %0d want 3", level); else passed++;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b want 0", out_valid); else passed++;
    checks++; if (level !== '0) $display("FAIL mid_rst_level: got %0d want 0", level); else passed++;
    repeat (2) tick();
    rst = 1'b0;
    checks++; if (out_code !== 2'b00 || overflow !== 1'b0)
      $display("FAIL mid_rst_out: code %0b ovf %0b want 00 / 0", out_code, overflow); else passed++;
  endtask

  task automatic test_ts_wrap();
    code_in = 2'b00;
    for (int i = 0; i < 300 && m_ts != 8'd252; i++) tick();
    code_in = 2'b01;
    repeat (4) tick();
    checks++; if (out_code !== 2'b01 || out_stamp !== 8'd255)
      $display("FAIL wrap_255: code %0b stamp %0d want 01 / 255", out_code, out_stamp); else passed++;
    code_in = 2'b10;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    repeat (3) tick();
    checks++; if (out_code !== 2'b10 || out_stamp !== 8'd3)
      $display("FAIL wrap_3: code %0b stamp %0d want 10 / 3", out_code, out_stamp); else passed++;
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 120; seg++) begin
      code_in = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 7);
      for (int c = 0; c < hold; c++) begin
        out_ready = ($urandom_range(0, 3) == 0);
        clear_ovf = ($urandom_range(0, 15) == 0);
        tick();
        checks++; if (level !== LW'(mq.size()))
          $display("FAIL rnd_level: got %0d want %0d", level, mq.size()); else passed++;
        checks++; if (out_valid !== (mq.size() != 0))
          $display("FAIL rnd_valid: got %0b want %0b", out_valid, mq.size() != 0); else passed++;
        checks++; if (overflow !== m_ovf)
          $display("FAIL rnd_ovf: got %0b want %0b", overflow, m_ovf); else passed++;
        if (mq.size() != 0) begin
          checks++; if (out_code !== mq[0].code || out_stamp !== mq[0].stamp)
            $display("FAIL rnd_head: got %0b/%0d want %0b/%0d", out_code, out_stamp, mq[0].code, mq[0].stamp); else passed++;
        end
      end
    end
    out_ready = 1'b0;
    clear_ovf = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_event();
    test_glitch();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_ts_wrap();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule
